// File: rtl/toggle_port_responder_pkg.sv
// toggle_port_pkg: shared request entry and FSM state types for the toggle port responder
package toggle_port_pkg;
  localparam int AW_DEF = 23;
  localparam int DW_DEF = 16;
  typedef struct packed {
    logic [AW_DEF-1:0] a;
    logic [1:0]        ds;
    logic              we;
    logic [DW_DEF-1:0] d;
  } req_entry_t;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/toggle_port_responder_fifo.sv
// req_fifo: single-clock request FIFO; a push into a full FIFO is accepted when a pop happens on the same edge
module req_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (PW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/toggle_port_responder.sv
// toggle_port_responder: turns port_req toggles into queued req/ready memory transactions, acking each by a toggle
module toggle_port_responder
  import toggle_port_pkg::*;
#(
  parameter int AW    = 23,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [DW-1:0] port_d,
  output logic [DW-1:0] port_q,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  input  logic          mem_ready,
  output logic          busy,
  output logic          overflow
);
  localparam int EW = AW + 2 + 1 + DW;
  state_t                 state, state_nxt;
  logic                   req_seen, new_req, pop, done, full, empty;
  logic [$clog2(DEPTH):0] count;
  logic [EW-1:0]          head;
  assign new_req = port_req ^ req_seen;
  assign busy    = (count != '0) || (state == ISSUE);
  req_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (new_req),
    .pop     (pop),
    .wdata   ({port_a, port_ds, port_we, port_d}),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  always_comb begin
    pop       = (state == IDLE) && !empty;
    done      = (state == ISSUE) && mem_ready;
    state_nxt = pop ? ISSUE : (done ? IDLE : state);
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_seen <= 1'b0;
      port_ack <= 1'b0;
      port_q   <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_ds   <= '0;
      mem_d    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_seen <= port_req;
      // a dropped request is never acked, so the initiator sees the parity slip
      if (new_req && full && !pop) overflow <= 1'b1;
      if (pop) begin
        {mem_a, mem_ds, mem_we, mem_d} <= head;
        mem_req <= 1'b1;
      end
      if (done) begin
        mem_req  <= 1'b0;
        port_ack <= ~port_ack;
        if (!mem_we) port_q <= mem_q;
      end
    end
  end
endmodule

// File: tb/tb_toggle_port_responder.sv
// tb_toggle_port_responder: directed tests against a queue-level model of the toggle responder
module tb_toggle_port_responder;
  import toggle_port_pkg::*;
  localparam int AW = 23, DW = 16, DEPTH = 4;
  logic clk_sys = 0, reset = 1, port_req = 0, port_we = 0, mem_ready = 0;
  logic [AW-1:0] port_a = 0;
  logic [1:0] port_ds = 0;
  logic [DW-1:0] port_d = 0, mem_q = 0;
  logic port_ack, mem_req, mem_we, busy, overflow;
  logic [DW-1:0] port_q, mem_d;
  logic [AW-1:0] mem_a;
  logic [1:0] mem_ds;
  int n_tests = 0, n_fail = 0;
  always #5 clk_sys = ~clk_sys;
  toggle_port_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset(reset), .port_req(port_req), .port_ack(port_ack),
    .port_a(port_a), .port_ds(port_ds), .port_we(port_we), .port_d(port_d), .port_q(port_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds), .mem_d(mem_d),
    .mem_q(mem_q), .mem_ready(mem_ready), .busy(busy), .overflow(overflow)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: queue of accepted requests plus the one in flight
  req_entry_t mq[$];
  req_entry_t cur = '0;
  bit inflight = 0, pop_now = 0;
  logic m_ack = 0, m_seen = 0, m_ovf = 0;
  logic [DW-1:0] m_q = 0;
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mq.delete();
      cur = '0; inflight = 0; m_ack = 0; m_seen = 0; m_ovf = 0; m_q = 0;
    end else begin
      pop_now = !inflight && mq.size() > 0;
      if (inflight && mem_ready) begin
        inflight = 0;
        m_ack = ~m_ack;
        if (!cur.we) m_q = mem_q;
      end
      if (pop_now) begin
        cur = mq.pop_front();
        inflight = 1;
      end
      if (port_req != m_seen) begin
        if (mq.size() < DEPTH) mq.push_back('{a: port_a, ds: port_ds, we: port_we, d: port_d});
        else m_ovf = 1;
      end
      m_seen = port_req;
    end
  end
  always @(negedge clk_sys) begin
    if (!reset) begin
      chk("mem_req", mem_req, inflight);
      chk("mem_a", mem_a, cur.a);
      chk("mem_ds", mem_ds, cur.ds);
      chk("mem_we", mem_we, cur.we);
      chk("mem_d", mem_d, cur.d);
      chk("port_ack", port_ack, m_ack);
      chk("port_q", port_q, m_q);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, inflight || mq.size() != 0);
    end
  end
  // memory responder: raises mem_ready dly cycles into a request unless held off
  int dly = 0, cnt = 0, req_cycles = 0;
  bit hold = 0;
  always @(negedge clk_sys) begin
    mem_q = (mem_a == 23'h7FF) ? 16'hBEEF : (mem_a[15:0] ^ 16'h1234);
    if (mem_req) req_cycles++;
    if (reset || !mem_req) begin mem_ready = 0; cnt = 0; end
    else if (hold) mem_ready = 0;
    else if (cnt >= dly) mem_ready = 1;
    else cnt++;
  end
  logic [AW-1:0] issued[$];
  always @(posedge clk_sys) if (!reset && mem_req && mem_ready) issued.push_back(mem_a);
  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1; port_req = 0; hold = 0; dly = 0;
    repeat (2) @(negedge clk_sys);
    reset = 0;
    issued.delete();
    req_cycles = 0;
  endtask
  task automatic toggle(input logic [AW-1:0] a, input logic [1:0] ds, input logic we, input logic [DW-1:0] d);
    port_a = a; port_ds = ds; port_we = we; port_d = d;
    port_req = ~port_req;
    @(negedge clk_sys);
  endtask
  task automatic wait_ack(input logic exp, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_sys);
      if (port_ack == exp) begin cyc = i; break; end
    end
  endtask
  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_sys);
      ok = !busy;
    end
    chk(name, ok, 1);
  endtask
  initial begin
    int cyc;
    @(negedge clk_sys);
    chk("rst_ack", port_ack, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_port_q", port_q, 0);
    chk("rst_mem_a", mem_a, 0);
    reset = 0;
    @(negedge clk_sys);
    // single write, ready immediately
    req_cycles = 0;
    toggle(23'h000100, 2'b01, 1'b1, 16'h00A5);
    wait_ack(1'b1, cyc);
    chk("t1_latency", cyc, 2);
    @(negedge clk_sys);
    chk("t1_req_cycles", req_cycles, 1);
    chk("t1_mem_a", mem_a, 23'h100);
    chk("t1_mem_d", mem_d, 16'h00A5);
    chk("t1_mem_ds", mem_ds, 2'b01);
    chk("t1_busy", busy, 0);
    chk("t1_port_q", port_q, 0);
    // read with slow ready
    req_cycles = 0;
    dly = 5;
    toggle(23'h7FF, 2'b11, 1'b0, 16'h0000);
    wait_ack(1'b0, cyc);
    chk("t2_latency", cyc, 7);
    @(negedge clk_sys);
    chk("t2_req_cycles", req_cycles, 6);
    chk("t2_port_q", port_q, 16'hBEEF);
    // burst of four on consecutive cycles
    do_reset();
    dly = 3;
    for (int i = 0; i < 4; i++) toggle(AW'(i), 2'b11, 1'b1, 16'h1000 + 16'(i));
    wait_idle("t3_idle");
    chk("t3_count", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("t3_order", issued[i], i);
    chk("t3_overflow", overflow, 0);
    chk("t3_ack_eq_req", port_ack, port_req);
    // overflow: six toggles while ready is held off
    do_reset();
    hold = 1;
    for (int i = 0; i < 6; i++) toggle(AW'(16 + i), 2'b10, 1'b1, 16'(i));
    repeat (2) @(negedge clk_sys);
    chk("t4_overflow", overflow, 1);
    chk("t4_mem_req", mem_req, 1);
    chk("t4_mem_a", mem_a, 16);
    hold = 0;
    wait_idle("t4_idle");
    chk("t4_count", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++) chk("t4_order", issued[i], 16 + i);
    chk("t4_ack_ne_req", port_ack ^ port_req, 1);
    chk("t4_overflow_sticky", overflow, 1);
    // full FIFO, new toggle lands on the edge that pops
    do_reset();
    hold = 1;
    for (int i = 0; i < 5; i++) toggle(AW'(32 + i), 2'b11, 1'b1, 16'(i));
    hold = 0;
    wait_ack(1'b1, cyc);
    chk("t5_ack_seen", cyc > 0, 1);
    toggle(AW'(37), 2'b11, 1'b1, 16'h0037);
    wait_idle("t5_idle");
    chk("t5_overflow", overflow, 0);
    chk("t5_count", issued.size(), 6);
    chk("t5_last", issued.size() == 6 ? 32'(issued[5]) : 32'hFFFF_FFFF, 37);
    chk("t5_ack_eq_req", port_ack, port_req);
    // reset while a request is in flight
    do_reset();
    toggle(AW'(40), 2'b11, 1'b1, 16'h0040);
    wait_ack(1'b1, cyc);
    chk("t6_first_ack", port_ack, 1);
    hold = 1;
    toggle(AW'(41), 2'b11, 1'b0, 16'h0000);
    repeat (2) @(negedge clk_sys);
    chk("t6_inflight", mem_req, 1);
    #2;
    reset = 1;
    port_req = 0;
    #1;
    chk("t6_async_req", mem_req, 0);
    chk("t6_async_ack", port_ack, 0);
    chk("t6_async_busy", busy, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 0;
    hold = 0;
    repeat (5) @(negedge clk_sys);
    chk("t6_no_spurious_req", mem_req, 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_ack", port_ack, 0);
    chk("t6_issued", issued.size(), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/toggle_port_responder.md
Name: toggle_port_responder

Overview:
- Responder end of the toggle req/ack SDRAM-port handshake used by the ROM download controller and the graphics/CPU ports.
- Each transition of port_req is one request: write or read, word address, byte strobes, data. Each completed request produces exactly one transition of port_ack.
- Requests can toggle faster than the memory completes them, because the download initiator never waits for ack. Incoming requests are therefore buffered in a small FIFO and issued one at a time to a simple req/ready memory bus.
- Sits between the download logic and an SDRAM/BRAM back-end controller.

Parameters:
AW, 23, word address width
DW, 16, data width
DEPTH, 4, request FIFO depth (power of two, >=2)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous active-high reset
port_req  in  1  request toggle; every change is one request
port_ack  out  1  ack toggle; changes once per completed request
port_a  in  AW  word address, captured with the toggle
port_ds  in  2  byte strobes {hi,lo}, captured with the toggle
port_we  in  1  1=write, 0=read, captured with the toggle
port_d  in  DW  write data, captured with the toggle
port_q  out  DW  read data of the last completed read
mem_req  out  1  memory request, held until accepted
mem_we  out  1  write enable for the current request
mem_a  out  AW  address for the current request
mem_ds  out  2  byte strobes for the current request
mem_d  out  DW  write data for the current request
mem_q  in  DW  read data, valid in the cycle mem_ready is high
mem_ready  in  1  completion strobe for the current request
busy  out  1  FIFO not empty or FSM not IDLE
overflow  out  1  sticky: a request was dropped

Behaviour:
- Reset values: port_ack=0, port_q=0, mem_req=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0, busy=0, overflow=0. Internal req_seen=0, FIFO empty, state=IDLE.
- Initiator contract: port_req must be 0 while reset is asserted.
- Edge detect: a request is detected at edge E when port_req != req_seen. req_seen <= port_req at every edge.
- Capture: {port_a, port_ds, port_we, port_d} are sampled at the same edge E that detects the request.
- Push rules:
  - FIFO not full: entry is pushed at E.
  - FIFO full and a pop occurs at E: push is still accepted; count is unchanged.
  - FIFO full and no pop at E: request is dropped, overflow <= 1 (sticky until reset), and port_ack is NOT toggled for it.
- FSM states: IDLE, ISSUE.
  - IDLE, FIFO non-empty at edge: pop head, load the mem_* outputs from it, mem_req <= 1, go to ISSUE.
  - ISSUE: mem_req and all mem_* outputs are held stable until mem_ready=1 is sampled.
  - ISSUE with mem_ready=1 at edge: mem_req <= 0, port_ack <= ~port_ack, port_q <= mem_q if mem_we=0 (port_q unchanged on writes), go to IDLE.
  - mem_ready while not in ISSUE is ignored.
- Latency: toggle before E0 → push at E0 → mem_req rises at E1 → with mem_ready high after E1, ack toggles at E2.
  - Minimum is 3 edges per request. Back-to-back queued requests complete every 2 edges.
- Ordering: requests are issued strictly FIFO. Ack toggles correspond 1:1 with accepted requests.
- When idle and the FIFO is empty: port_ack == port_req parity, minus the count of dropped requests mod 2.
- busy is combinational: (count != 0) | (state == ISSUE).
- Reset mid-operation: everything returns to reset values immediately, the in-flight request is abandoned, and mem_req drops asynchronously.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits and never exceeds DEPTH.

Decomposition:
- Shared package (toggle_port_pkg): req_entry_t struct {a, ds, we, d}; state enum {IDLE, ISSUE}.
- One sub-module: req_fifo, a synchronous single-clock FIFO with full/empty, count, and simultaneous push/pop when full.

Test Plan:
1. Single write: reset, toggle port_req 0→1 with a=23'h000100, ds=2'b01, we=1, d=16'h00A5; mem_ready tied high → mem_req high for exactly 1 cycle with mem_a=0x100, mem_d=0x00A5, mem_ds=01; port_ack=1 two edges after push; busy low after.
2. Read: toggle with we=0, a=0x7FF; mem_ready asserted 5 cycles after mem_req with mem_q=16'hBEEF → mem_req held stable for the 5 cycles; port_q=BEEF and ack toggles on the ready edge.
3. Burst of 4 toggles on consecutive cycles, a=0..3, mem_ready delayed 3 cycles each → issued in order 0,1,2,3; 4 ack toggles; overflow=0; final port_ack == port_req.
4. Overflow: DEPTH=4, mem_ready held low, 6 toggles → after 5th accepted (1 in flight + 4 queued) the 6th sets overflow=1; release ready → exactly 5 completions; port_ack != port_req.
5. Full + simultaneous pop: FIFO full, toggle arrives on the edge mem_ready completes and IDLE pops → request accepted, no overflow.
6. Reset mid-ISSUE: assert reset while mem_req=1 → mem_req=0 and port_ack=0 immediately; after release with port_req=0, no spurious request.
